// File: rtl/post_add_pkg.sv
// rtl/post_add_pkg.sv - shared types and sizing helpers for the post-adder scheduler
package post_add_pkg;

   localparam int POST_ADD_WIDTH    = 48;
   localparam int POST_ADD_ID_MAX_W = 3;

   function automatic int id_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   typedef struct packed {
      logic [POST_ADD_WIDTH-1:0]    in0;
      logic [POST_ADD_WIDTH-1:0]    in1;
      logic                         cin;
      logic                         add_sub;
      logic [POST_ADD_ID_MAX_W-1:0] id;
   } post_add_op_t;

   typedef struct packed {
      logic [POST_ADD_WIDTH-1:0]    out;
      logic                         cout;
      logic [POST_ADD_ID_MAX_W-1:0] id;
   } post_add_res_t;

endpackage

// File: rtl/Post_adder_substracter.sv
// rtl/Post_adder_substracter.sv - combinational post-adder/subtracter, result mod 2^(WIDTH+1)
module Post_adder_substracter #(
   parameter int WIDTH = 48
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             cin,
   input  logic             add_sub,
   output logic [WIDTH-1:0] out,
   output logic             cout
);

   logic [WIDTH:0] sum;

   // For subtract the top bit of the extended difference is the borrow.
   always_comb begin
      if (add_sub) begin
         sum = {1'b0, in0} - ({1'b0, in1} + {{WIDTH{1'b0}}, cin});
      end else begin
         sum = {1'b0, in0} + {1'b0, in1} + {{WIDTH{1'b0}}, cin};
      end
   end

   assign {cout, out} = sum;

endmodule

// File: rtl/post_add_rr_grant.sv
// rtl/post_add_rr_grant.sv - pointer-based round-robin grant; POST_ADD_LOCK_EN adds req_lock
module post_add_rr_grant
   import post_add_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req_valid,
`ifdef POST_ADD_LOCK_EN
   input  logic [NUM_REQ-1:0] req_lock,
`endif
   output logic [NUM_REQ-1:0] req_ready,
   output logic [ID_W-1:0]    grant_id,
   output logic               accept
);

   logic [ID_W-1:0] ptr_q, ptr_d;
   logic            found;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      return ID_W'(sum);
   endfunction

   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[wrap_add(ptr_q, k)]) begin
            found    = 1'b1;
            grant_id = wrap_add(ptr_q, k);
         end
      end
   end

   // Ready is withheld during reset and while the pipeline is frozen.
   assign accept    = found & en & rst_n;
   assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
`ifdef POST_ADD_LOCK_EN
         ptr_d = req_lock[grant_id] ? grant_id : wrap_add(grant_id, 1);
`else
         ptr_d = wrap_add(grant_id, 1);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/post_add_rr_scheduler.sv
// rtl/post_add_rr_scheduler.sv - round-robin sharing of one post-adder, two-stage pipeline, ID-tagged results
// Optional macro POST_ADD_LOCK_EN adds req_lock to hold the grant for chained bursts.
module post_add_rr_scheduler
   import post_add_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = POST_ADD_WIDTH,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_in0,
   input  logic [NUM_REQ*WIDTH-1:0] req_in1,
   input  logic [NUM_REQ-1:0]       req_cin,
   input  logic [NUM_REQ-1:0]       req_add_sub,
`ifdef POST_ADD_LOCK_EN
   input  logic [NUM_REQ-1:0]       req_lock,
`endif
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_out,
   output logic                     rsp_cout
);

   if (WIDTH != POST_ADD_WIDTH || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_cfg
      $error("post_add_rr_scheduler: WIDTH must equal POST_ADD_WIDTH and NUM_REQ must be 2..8");
   end

   logic [ID_W-1:0] grant_id;
   logic            accept;

   post_add_op_t  s1_q, s1_d;
   logic          s1_valid_q, s1_valid_d;
   post_add_res_t res_q, res_d;
   logic          rsp_valid_q, rsp_valid_d;

   logic [WIDTH-1:0] dp_out;
   logic             dp_cout;

   post_add_rr_grant #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_grant (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req_valid (req_valid),
`ifdef POST_ADD_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_ready (req_ready),
      .grant_id  (grant_id),
      .accept    (accept)
   );

   Post_adder_substracter #(
      .WIDTH (WIDTH)
   ) u_post_add (
      .in0     (s1_q.in0),
      .in1     (s1_q.in1),
      .cin     (s1_q.cin),
      .add_sub (s1_q.add_sub),
      .out     (dp_out),
      .cout    (dp_cout)
   );

   // en=0 freezes both stages; the result register only loads on a live stage-1 op.
   always_comb begin
      s1_d        = s1_q;
      s1_valid_d  = s1_valid_q;
      res_d       = res_q;
      rsp_valid_d = rsp_valid_q;
      if (en) begin
         s1_valid_d = accept;
         if (accept) begin
            s1_d.in0     = req_in0[grant_id*WIDTH +: WIDTH];
            s1_d.in1     = req_in1[grant_id*WIDTH +: WIDTH];
            s1_d.cin     = req_cin[grant_id];
            s1_d.add_sub = req_add_sub[grant_id];
            s1_d.id      = POST_ADD_ID_MAX_W'(grant_id);
         end
         rsp_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            res_d.out  = dp_out;
            res_d.cout = dp_cout;
            res_d.id   = s1_q.id;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s1_valid_q  <= 1'b0;
         res_q       <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s1_valid_q  <= s1_valid_d;
         res_q       <= res_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_out   = res_q.out;
   assign rsp_cout  = res_q.cout;
   assign rsp_id    = res_q.id[ID_W-1:0];

   if (ID_W < POST_ADD_ID_MAX_W) begin : g_id_pad
      logic unused_id_hi;
      assign unused_id_hi = |res_q.id[POST_ADD_ID_MAX_W-1:ID_W];
   end

endmodule

// File: tb/tb_post_add_rr_scheduler.sv
// tb/tb_post_add_rr_scheduler.sv - directed self-checking bench for post_add_rr_scheduler
module tb_post_add_rr_scheduler;

   localparam int N = 4;
   localparam int W = 48;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           en;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_in0;
   logic [N*W-1:0] req_in1;
   logic [N-1:0]   req_cin;
   logic [N-1:0]   req_add_sub;
`ifdef POST_ADD_LOCK_EN
   logic [N-1:0]   req_lock;
`endif
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_out;
   logic           rsp_cout;

   int n_vec = 0;
   int n_bad = 0;

   post_add_rr_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_in0     (req_in0),
      .req_in1     (req_in1),
      .req_cin     (req_cin),
      .req_add_sub (req_add_sub),
`ifdef POST_ADD_LOCK_EN
      .req_lock    (req_lock),
`endif
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_out     (rsp_out),
      .rsp_cout    (rsp_cout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic sub);
      req_in0[i*W +: W] = a;
      req_in1[i*W +: W] = b;
      req_cin[i]        = c;
      req_add_sub[i]    = sub;
   endtask

   task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [W-1:0] out,
                          input logic cout);
      chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_id"},    64'(rsp_id),    64'(id));
      chk({tag, "_out"},   64'(rsp_out),   64'(out));
      chk({tag, "_cout"},  64'(rsp_cout),  64'(cout));
   endtask

   initial begin
      rst_n       = 1'b0;
      en          = 1'b1;
      req_valid   = 4'hF;
      req_in0     = '0;
      req_in1     = '0;
      req_cin     = '0;
      req_add_sub = '0;
`ifdef POST_ADD_LOCK_EN
      req_lock    = '0;
`endif
      tick();
      tick();
      chk("rst_ready",     64'(req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rsp_id",    64'(rsp_id),    64'h0);
      chk("rst_rsp_out",   64'(rsp_out),   64'h0);
      chk("rst_rsp_cout",  64'(rsp_cout),  64'h0);
      rst_n     = 1'b1;
      req_valid = '0;
      tick();

      // single add on requester 0: 5 + 3 + 1
      set_op(0, 48'd5, 48'd3, 1'b1, 1'b0);
      req_valid = 4'b0001;
      #1 chk("t1_ready", 64'(req_ready), 64'b0001);
      tick();
      req_valid = '0;
      #1 chk("t1_lat1_valid", 64'(rsp_valid), 64'd0);
      tick();
      chk_rsp("t1", 2'd0, 48'd9, 1'b0);
      tick();
      chk("t1_pulse_end", 64'(rsp_valid), 64'd0);

      // requester 1: 3 - 5 borrows, then all-ones + 1 carries out
      set_op(1, 48'd3, 48'd5, 1'b0, 1'b1);
      req_valid = 4'b0010;
      #1 chk("t2_ready_a", 64'(req_ready), 64'b0010);
      tick();
      set_op(1, 48'hFFFF_FFFF_FFFF, 48'd1, 1'b0, 1'b0);
      #1 chk("t2_ready_b", 64'(req_ready), 64'b0010);
      tick();
      req_valid = '0;
      chk_rsp("t2_sub", 2'd1, 48'hFFFF_FFFF_FFFE, 1'b1);
      tick();
      chk_rsp("t2_add", 2'd1, 48'h0, 1'b1);
      tick();
      chk("t2_pulse_end", 64'(rsp_valid), 64'd0);

      // reset to return the pointer to 0, then steady load from all four
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < N; i++) set_op(i, 48'(100 + i), 48'(i), 1'b0, 1'b0);
      req_valid = 4'hF;
      for (int k = 0; k < 10; k++) begin
         if (k == 8) req_valid = '0;
         #1;
         if (k < 8) chk($sformatf("t3_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
         if (k >= 2) chk_rsp($sformatf("t3_rsp_%0d", k - 2), 2'((k - 2) % 4),
                             48'(100 + 2 * ((k - 2) % 4)), 1'b0);
         tick();
      end
      chk("t3_drain", 64'(rsp_valid), 64'd0);

      // accept 0, freeze 3 cycles, then accept 2; pointer is 0 here
      set_op(0, 48'd10, 48'd20, 1'b0, 1'b0);
      set_op(2, 48'd50, 48'd8, 1'b0, 1'b1);
      req_valid = 4'b0001;
      #1 chk("t4_ready0", 64'(req_ready), 64'b0001);
      tick();
      req_valid = 4'b0100;
      en        = 1'b0;
      #1 chk("t4_ready_frozen", 64'(req_ready), 64'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("t4_frz_valid_%0d", k), 64'(rsp_valid), 64'd0);
         chk($sformatf("t4_frz_ready_%0d", k), 64'(req_ready), 64'h0);
      end
      en = 1'b1;
      #1 chk("t4_ready2", 64'(req_ready), 64'b0100);
      tick();
      req_valid = '0;
      chk_rsp("t4_r0", 2'd0, 48'd30, 1'b0);
      tick();
      chk_rsp("t4_r2", 2'd2, 48'd42, 1'b0);
      tick();
      chk("t4_pulse_end", 64'(rsp_valid), 64'd0);

      // reset one cycle after an accept on requester 3 (pointer is 3)
      set_op(3, 48'd7, 48'd9, 1'b1, 1'b0);
      req_valid = 4'b1000;
      #1 chk("t5_ready3", 64'(req_ready), 64'b1000);
      tick();
      req_valid = '0;
      rst_n     = 1'b0;
      #1;
      chk("t5_rst_valid", 64'(rsp_valid), 64'd0);
      chk("t5_rst_out",   64'(rsp_out),   64'd0);
      chk("t5_rst_cout",  64'(rsp_cout),  64'd0);
      chk("t5_rst_id",    64'(rsp_id),    64'd0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("t5_post_valid_%0d", k), 64'(rsp_valid), 64'd0);
         chk($sformatf("t5_post_out_%0d", k),   64'(rsp_out),   64'd0);
      end
      req_valid = 4'hF;
      #1 chk("t5_ptr0", 64'(req_ready), 64'b0001);
      req_valid = '0;
      tick();
      tick();
      chk("t5_drop_noeffect", 64'(rsp_valid), 64'd0);

`ifdef POST_ADD_LOCK_EN
      // requester 2 locks for three ops while 3 waits
      req_valid = 4'b1100;
      req_lock  = 4'b0100;
      #1 chk("t6_grant_a", 64'(req_ready), 64'b0100);
      tick();
      chk("t6_grant_b", 64'(req_ready), 64'b0100);
      tick();
      req_lock = '0;
      #1 chk("t6_grant_c", 64'(req_ready), 64'b0100);
      tick();
      chk("t6_grant_d", 64'(req_ready), 64'b1000);
      req_valid = '0;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/post_add_rr_scheduler.md
Name: post_add_rr_scheduler

Overview:
- Shares one 48-bit post-adder/subtracter (existing Post_adder_substracter) among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Two-stage pipeline: operand register, then result register. Sustains one operation per cycle.
- Sits between the DSP48A1 slice control and the post-adder datapath. Returns each result tagged with the requester ID.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 48: operand and result width.
- ID_W, $clog2(NUM_REQ): width of the requester ID.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global advance; 0 freezes arbitration and both pipeline stages
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
- req_in0  in  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
- req_in1  in  NUM_REQ*WIDTH  packed operand B
- req_cin  in  NUM_REQ  carry-in per requester
- req_add_sub  in  NUM_REQ  0 = add, 1 = subtract
- rsp_valid  out  1  result valid, one-cycle pulse per result
- rsp_id  out  ID_W  requester that issued the result
- rsp_out  out  WIDTH  result
- rsp_cout  out  1  carry out (add) or borrow bit (subtract)

Behaviour:
- Reset (async, rst_n=0):
  - All stage-1/stage-2 registers clear.
  - rsp_valid=0, rsp_id=0, rsp_out=0, rsp_cout=0.
  - Priority pointer = 0.
  - req_ready=0 while rst_n=0.
- Arbitration is combinational from the pointer and req_valid:
  - Grant goes to the first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready = one-hot of the grant when en=1, else all zero.
  - No valid request: req_ready=0.
- On an accept at a rising edge:
  - Stage 1 captures in0, in1, cin, add_sub and id; s1_valid=1.
  - Pointer becomes (grant+1) mod NUM_REQ.
- No accept with en=1: s1_valid=0 and the pointer holds.
- Stage 2 (en=1):
  - Captures the datapath result of stage 1 into rsp_out/rsp_cout/rsp_id.
  - rsp_valid <= s1_valid.
- Latency: accept at edge N, rsp_valid high in the cycle after edge N+1.
- Throughput: 1 accept per cycle. A steady multi-requester load is served in strict rotation.
- Arithmetic, computed 49 bits wide, mod 2^49:
  - Add: {cout,out} = in0 + in1 + cin.
  - Subtract: {cout,out} = {0,in0} - ({0,in1} + cin). cout=1 means a borrow.
- en=0:
  - No accepts; pointer, stage 1 and stage 2 hold.
  - rsp_valid holds its value but is not re-counted: the consumer qualifies it with en.
- Requester drops req_valid before an accept: no effect, no state change.
- Reset asserted mid-operation: in-flight operations are discarded, and no rsp_valid follows after release.
- Outputs and registers never produce X for any input combination after reset.

Optional Feature:
- Macro POST_ADD_LOCK_EN adds input req_lock [NUM_REQ].
- With the macro defined:
  - While the granted requester holds req_lock[i]=1 on an accept, the pointer stays at i. The grant is held for back-to-back bursts, e.g. multi-word chained operations.
  - Lock is ignored if req_valid[i]=0; normal rotation then resumes from i+1.
- Without the macro: the port is absent and behaviour is pure round-robin.

Decomposition:
- Package post_add_pkg:
  - WIDTH default, ID_W function.
  - Packed struct post_add_op_t {in0, in1, cin, add_sub, id}.
  - Result struct {out, cout, id}.
- Sub-module post_add_rr_grant: the pointer-based round-robin grant (combinational grant plus registered pointer, lock handling).
- Datapath: instantiate the existing Post_adder_substracter between the stages. No new arithmetic module.

Test Plan:
- Reset, then req 0 only, add: in0=5, in1=3, cin=1 -> rsp_valid 2 cycles after accept, rsp_out=9, cout=0, rsp_id=0.
- Req 1, subtract: in0=3, in1=5, cin=0 -> rsp_out=48'hFFFF_FFFF_FFFE, cout=1. Add 48'hFFFF_FFFF_FFFF + 1, cin=0 -> out=0, cout=1.
- All 4 valid continuously for 8 cycles, pointer starting at 0 -> grant order 0,1,2,3,0,1,2,3; 8 responses back-to-back with matching IDs.
- Accept on 0 and 2 with en dropped for 3 cycles between them -> no accepts while en=0, stages frozen, results emerge intact once en returns.
- rst_n pulsed low one cycle after an accept -> rsp_valid stays 0, all outputs 0, pointer 0.
- POST_ADD_LOCK_EN: req 2 valid with lock=1 for 3 ops while req 3 is also valid -> grants 2,2,2, then 3 after lock drops.
